// File: rtl/data_mem_unit.sv
// data_mem_unit: byte-addressed data memory for the MEM stage. Supports RV32I
// sub-word loads/stores, takes one request at a time over valid/ready and
// answers with a one-cycle response pulse a fixed number of cycles later.
//
// Handshake: a request transfers on the rising edge where req_valid && req_ready.
// req_ready is high only while idle, and all request fields are sampled on that
// edge alone. rsp_valid is a single-cycle pulse with no back-pressure.
// rsp_rdata/rsp_fault hold their last values between pulses.
module data_mem_unit #(
    parameter int DEPTH_WORDS = 256,
    parameter int RSP_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic        busy
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    // Latency is at most 8, so the wait counter never holds more than 7.
    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RSP_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    logic [31:0] mem_q [DEPTH_WORDS];

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_ready_q, req_ready_d;
    logic             busy_q, busy_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;
    logic             rsp_fault_q, rsp_fault_d;
    logic [31:0]      cap_data_q, cap_data_d;
    logic             cap_fault_q, cap_fault_d;

    logic [IDX_W-1:0] word_idx;
    logic [1:0]       off;
    logic             in_range;
    logic             f3_legal;
    logic             misaligned;
    logic             fault;
    logic             accept;
    logic [3:0]       byte_en;
    logic [31:0]      wr_data;
    logic [31:0]      rd_word;
    logic [31:0]      rd_shift;
    logic [31:0]      ld_result;

    // Decode the presented request: fault checks, store lanes and load extension.
    always_comb begin
        word_idx = req_addr[IDX_W+1:2];
        off      = req_addr[1:0];
        // Upper address bits never alias onto the array; any of them set is out of range.
        in_range = (req_addr[31:IDX_W+2] == '0);

        case (req_funct3)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            3'b100, 3'b101:         f3_legal = !req_we;
            default:                f3_legal = 1'b0;
        endcase

        misaligned = ((req_funct3[1:0] == 2'b01) && off[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (off != 2'b00));
        fault      = !in_range || !f3_legal || misaligned;
        accept     = req_valid && req_ready_q;

        // Replicate the right-aligned store data so every lane sees its byte.
        byte_en = 4'b0000;
        wr_data = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                byte_en = 4'b0001 << off;
                wr_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                byte_en = 4'b0011 << off;
                wr_data = {2{req_wdata[15:0]}};
            end
            default: byte_en = 4'b1111;
        endcase

        rd_word  = mem_q[word_idx];
        rd_shift = rd_word >> {off, 3'b000};
        case (req_funct3)
            3'b000:  ld_result = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  ld_result = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  ld_result = {24'd0, rd_shift[7:0]};
            3'b101:  ld_result = {16'd0, rd_shift[15:0]};
            default: ld_result = rd_word;
        endcase
        if (fault || req_we) begin
            ld_result = 32'd0;
        end
    end

    // Byte-lane store commits on the acceptance edge; the array has no reset.
    always_ff @(posedge clk) begin
        if (accept && req_we && !fault) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem_q[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Next-state logic for the IDLE -> WAIT -> RESP sequencer and its outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_ready_d = req_ready_q;
        busy_d      = busy_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_fault_d = rsp_fault_q;
        cap_data_d  = cap_data_q;
        cap_fault_d = cap_fault_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cap_data_d  = ld_result;
                    cap_fault_d = fault;
                    req_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    // Single-cycle latency skips WAIT and answers right after acceptance.
                    if (RSP_LATENCY == 1) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = ld_result;
                        rsp_fault_d = fault;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = cap_data_q;
                    rsp_fault_d = cap_fault_q;
                end
            end
            ST_RESP: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    // Sequencer state and registered outputs; reset drops any pending response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_fault_q <= 1'b0;
            cap_data_q  <= 32'd0;
            cap_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_fault_q <= rsp_fault_d;
            cap_data_q  <= cap_data_d;
            cap_fault_q <= cap_fault_d;
        end
    end

    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// tb_data_mem_unit: four instances of data_mem_unit with different latencies.
// Instance 0: 256 words, latency 1 (functional and random tests)
// Instance 1: 16 words, latency 3
// Instance 2: 16 words, latency 8
// Instance 3: 256 words, latency 4 (reset during an outstanding store)
module tb_data_mem_unit;

    logic        clk;
    logic        rst_n;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  vld;
    logic [3:0]  rdy;
    logic [3:0]  rsp_v;
    logic [3:0]  rsp_f;
    logic [3:0]  bsy;
    logic [31:0] rdata [4];

    int checks   = 0;
    int failures = 0;

    // Reference memory: byte address -> byte, filled only by modelled stores.
    logic [7:0] ref_mem [int unsigned];

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    data_mem_unit #(.DEPTH_WORDS(256), .RSP_LATENCY(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(vld[0]), .req_ready(rdy[0]),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_v[0]), .rsp_rdata(rdata[0]),
        .rsp_fault(rsp_f[0]), .busy(bsy[0])
    );
    data_mem_unit #(.DEPTH_WORDS(16), .RSP_LATENCY(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(vld[1]), .req_ready(rdy[1]),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_v[1]), .rsp_rdata(rdata[1]),
        .rsp_fault(rsp_f[1]), .busy(bsy[1])
    );
    data_mem_unit #(.DEPTH_WORDS(16), .RSP_LATENCY(8)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(vld[2]), .req_ready(rdy[2]),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_v[2]), .rsp_rdata(rdata[2]),
        .rsp_fault(rsp_f[2]), .busy(bsy[2])
    );
    data_mem_unit #(.DEPTH_WORDS(256), .RSP_LATENCY(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(vld[3]), .req_ready(rdy[3]),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_v[3]), .rsp_rdata(rdata[3]),
        .rsp_fault(rsp_f[3]), .busy(bsy[3])
    );

    // Behavioural model: access size, legality and extension from plain arithmetic.
    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, input int unsigned depth,
                                  output logic [31:0] rd, output logic flt, output logic known);
        int unsigned size;
        int unsigned ua;
        bit sgn;
        bit legal;
        logic [63:0] val;
        ua = a;
        size = 4;
        sgn = 1'b0;
        legal = 1'b0;
        case (f3)
            3'd0: begin size = 1; sgn = 1'b1; legal = 1'b1; end
            3'd1: begin size = 2; sgn = 1'b1; legal = 1'b1; end
            3'd2: begin size = 4; legal = 1'b1; end
            3'd4: begin size = 1; legal = !we; end
            3'd5: begin size = 2; legal = !we; end
            default: legal = 1'b0;
        endcase
        flt = !legal || ((ua % size) != 0) || ((ua / 4) >= depth);
        rd = 32'd0;
        known = 1'b1;
        if (flt) return;
        if (we) begin
            for (int i = 0; i < int'(size); i++) ref_mem[ua + i] = wd[8*i +: 8];
        end else begin
            val = 64'd0;
            for (int i = 0; i < int'(size); i++) begin
                if (!ref_mem.exists(ua + i)) known = 1'b0;
                else val = val | (64'(ref_mem[ua + i]) << (8 * i));
            end
            if (sgn && val[8*size-1]) val = val | (~64'd0 << (8 * size));
            rd = val[31:0];
        end
    endfunction

    // Driver: present one request on instance k, wait for its response pulse.
    // lat counts sampling points after the acceptance edge (1 = first cycle).
    task automatic do_req(input int k, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic flt, output int lat);
        int n;
        @(negedge clk);
        req_we = we;
        req_funct3 = f3;
        req_addr = a;
        req_wdata = wd;
        vld[k] = 1'b1;
        n = 0;
        while (rdy[k] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        vld[k] = 1'b0;
        lat = 1;
        while (rsp_v[k] !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (rsp_v[k] !== 1'b1) begin
            failures++;
            $display("FAIL rsp_timeout inst=%0d got_valid=%b exp_valid=1", k, rsp_v[k]);
        end
        rd = rdata[k];
        flt = rsp_f[k];
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        vld = 4'b0000;
        req_we = 1'b0;
        req_funct3 = 3'b000;
        req_addr = 32'd0;
        req_wdata = 32'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rdy[k] !== 1'b1) begin failures++; $display("FAIL reset_ready inst=%0d got=%b exp=1", k, rdy[k]); end
            checks++;
            if (bsy[k] !== 1'b0) begin failures++; $display("FAIL reset_busy inst=%0d got=%b exp=0", k, bsy[k]); end
            checks++;
            if (rsp_v[k] !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid inst=%0d got=%b exp=0", k, rsp_v[k]); end
            checks++;
            if (rdata[k] !== 32'd0) begin failures++; $display("FAIL reset_rdata inst=%0d got=%h exp=0", k, rdata[k]); end
            checks++;
            if (rsp_f[k] !== 1'b0) begin failures++; $display("FAIL reset_fault inst=%0d got=%b exp=0", k, rsp_f[k]); end
        end
    endtask

    task automatic test_byte_lane();
        logic [31:0] rd;
        logic fl;
        int lat;
        do_req(0, 1'b1, 3'b010, 32'h10, 32'h11223344, rd, fl, lat);
        checks++;
        if (fl !== 1'b0 || rd !== 32'd0) begin failures++; $display("FAIL sw_0x10 got=%b/%h exp=0/0", fl, rd); end
        do_req(0, 1'b1, 3'b000, 32'h12, 32'hFFFFFFA5, rd, fl, lat);
        checks++;
        if (fl !== 1'b0 || rd !== 32'd0) begin failures++; $display("FAIL sb_0x12 got=%b/%h exp=0/0", fl, rd); end
        do_req(0, 1'b0, 3'b010, 32'h10, 32'd0, rd, fl, lat);
        checks++;
        if (rd !== 32'h11A53344) begin failures++; $display("FAIL lw_0x10 got=%h exp=11a53344", rd); end
        checks++;
        if (fl !== 1'b0) begin failures++; $display("FAIL lw_0x10_fault got=%b exp=0", fl); end
        do_req(0, 1'b0, 3'b000, 32'h12, 32'd0, rd, fl, lat);
        checks++;
        if (rd !== 32'hFFFFFFA5) begin failures++; $display("FAIL lb_0x12 got=%h exp=ffffffa5", rd); end
        do_req(0, 1'b0, 3'b100, 32'h12, 32'd0, rd, fl, lat);
        checks++;
        if (rd !== 32'h000000A5) begin failures++; $display("FAIL lbu_0x12 got=%h exp=000000a5", rd); end
        do_req(0, 1'b0, 3'b001, 32'h12, 32'd0, rd, fl, lat);
        checks++;
        if (rd !== 32'h000011A5) begin failures++; $display("FAIL lh_0x12 got=%h exp=000011a5", rd); end
    endtask

    task automatic test_halfword();
        logic [31:0] rd;
        logic fl;
        int lat;
        do_req(0, 1'b1, 3'b010, 32'h20, 32'h00000000, rd, fl, lat);
        do_req(0, 1'b1, 3'b001, 32'h22, 32'h12348001, rd, fl, lat);
        checks++;
        if (fl !== 1'b0) begin failures++; $display("FAIL sh_0x22_fault got=%b exp=0", fl); end
        do_req(0, 1'b0, 3'b010, 32'h20, 32'd0, rd, fl, lat);
        checks++;
        if (rd !== 32'h80010000) begin failures++; $display("FAIL lw_0x20 got=%h exp=80010000", rd); end
        do_req(0, 1'b0, 3'b001, 32'h22, 32'd0, rd, fl, lat);
        checks++;
        if (rd !== 32'hFFFF8001) begin failures++; $display("FAIL lh_0x22 got=%h exp=ffff8001", rd); end
        do_req(0, 1'b0, 3'b101, 32'h22, 32'd0, rd, fl, lat);
        checks++;
        if (rd !== 32'h00008001) begin failures++; $display("FAIL lhu_0x22 got=%h exp=00008001", rd); end
    endtask

    task automatic test_faults();
        logic [31:0] rd;
        logic fl;
        int lat;
        do_req(0, 1'b0, 3'b010, 32'h11, 32'd0, rd, fl, lat);
        checks++;
        if (fl !== 1'b1 || rd !== 32'd0) begin failures++; $display("FAIL lw_0x11 got=%b/%h exp=1/0", fl, rd); end
        do_req(0, 1'b1, 3'b001, 32'h23, 32'h0000BEEF, rd, fl, lat);
        checks++;
        if (fl !== 1'b1 || rd !== 32'd0) begin failures++; $display("FAIL sh_0x23 got=%b/%h exp=1/0", fl, rd); end
        do_req(0, 1'b0, 3'b000, 32'h400, 32'd0, rd, fl, lat);
        checks++;
        if (fl !== 1'b1 || rd !== 32'd0) begin failures++; $display("FAIL lb_range got=%b/%h exp=1/0", fl, rd); end
        do_req(0, 1'b0, 3'b011, 32'h10, 32'd0, rd, fl, lat);
        checks++;
        if (fl !== 1'b1 || rd !== 32'd0) begin failures++; $display("FAIL ld_f3_011 got=%b/%h exp=1/0", fl, rd); end
        do_req(0, 1'b1, 3'b100, 32'h10, 32'h000000EE, rd, fl, lat);
        checks++;
        if (fl !== 1'b1) begin failures++; $display("FAIL st_f3_100 got=%b exp=1", fl); end
        do_req(0, 1'b1, 3'b010, 32'h10000010, 32'hCAFEF00D, rd, fl, lat);
        checks++;
        if (fl !== 1'b1) begin failures++; $display("FAIL sw_alias got=%b exp=1", fl); end
        do_req(0, 1'b0, 3'b010, 32'h10, 32'd0, rd, fl, lat);
        checks++;
        if (rd !== 32'h11A53344 || fl !== 1'b0) begin failures++; $display("FAIL reread_0x10 got=%b/%h exp=0/11a53344", fl, rd); end
        do_req(0, 1'b0, 3'b010, 32'h20, 32'd0, rd, fl, lat);
        checks++;
        if (rd !== 32'h80010000) begin failures++; $display("FAIL reread_0x20 got=%h exp=80010000", rd); end
    endtask

    // Back-to-back requests with req_valid held; expected handshake timeline
    // follows from "one accept, then RSP_LATENCY busy cycles, then ready again".
    task automatic test_latency(input int k, input int lat_cfg);
        int j;
        int pulses;
        logic v;
        @(negedge clk);
        req_we = 1'b1;
        req_funct3 = 3'b010;
        req_addr = 32'h0;
        req_wdata = $urandom;
        j = lat_cfg + 1;
        pulses = 0;
        for (int c = 0; c < 4 * (lat_cfg + 1) + 2; c++) begin
            v = (c < 3 * (lat_cfg + 1));
            vld[k] = v;
            @(negedge clk);
            if (v && j == lat_cfg + 1) j = 1;
            else if (j <= lat_cfg) j++;
            checks++;
            if (rsp_v[k] !== (j == lat_cfg)) begin
                failures++;
                $display("FAIL lat%0d_rsp_valid cyc=%0d got=%b exp=%b", lat_cfg, c, rsp_v[k], (j == lat_cfg));
            end
            checks++;
            if (rdy[k] !== (j == lat_cfg + 1)) begin
                failures++;
                $display("FAIL lat%0d_ready cyc=%0d got=%b exp=%b", lat_cfg, c, rdy[k], (j == lat_cfg + 1));
            end
            checks++;
            if (bsy[k] !== (j <= lat_cfg)) begin
                failures++;
                $display("FAIL lat%0d_busy cyc=%0d got=%b exp=%b", lat_cfg, c, bsy[k], (j <= lat_cfg));
            end
            if (rsp_v[k] === 1'b1) pulses++;
        end
        vld[k] = 1'b0;
        checks++;
        if (pulses != 3) begin failures++; $display("FAIL lat%0d_pulses got=%0d exp=3", lat_cfg, pulses); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        logic [31:0] rd;
        logic fl;
        int lat;
        @(negedge clk);
        req_we = 1'b1;
        req_funct3 = 3'b010;
        req_addr = 32'h40;
        req_wdata = 32'hDEADBEEF;
        vld[3] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vld[3] = 1'b0;
        seen = rsp_v[3];
        @(negedge clk);
        seen = seen | rsp_v[3];
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bsy[3] !== 1'b0 || rdy[3] !== 1'b1) begin
            failures++;
            $display("FAIL midreset_idle got_busy=%b got_ready=%b exp=0/1", bsy[3], rdy[3]);
        end
        repeat (2) begin
            @(negedge clk);
            seen = seen | rsp_v[3];
        end
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            seen = seen | rsp_v[3];
        end
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL midreset_no_rsp got=%b exp=0", seen); end
        do_req(3, 1'b0, 3'b010, 32'h40, 32'd0, rd, fl, lat);
        checks++;
        if (rd !== 32'hDEADBEEF || fl !== 1'b0) begin failures++; $display("FAIL midreset_lw got=%b/%h exp=0/deadbeef", fl, rd); end
        checks++;
        if (lat != 4) begin failures++; $display("FAIL midreset_latency got=%0d exp=4", lat); end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, a, wd;
        logic fl, efl, known, we;
        logic [2:0] f3;
        int lat;
        for (int w = 0; w < 32; w++) begin
            wd = $urandom;
            a = 32'(w * 4);
            model(1'b1, 3'b010, a, wd, 256, erd, efl, known);
            do_req(0, 1'b1, 3'b010, a, wd, rd, fl, lat);
            checks++;
            if (fl !== efl) begin failures++; $display("FAIL rnd_init_fault addr=%h got=%b exp=%b", a, fl, efl); end
        end
        for (int i = 0; i < 80; i++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0:       a = 32'h400 + 32'($urandom_range(0, 15));
                1:       a = $urandom;
                default: a = 32'($urandom_range(0, 127));
            endcase
            wd = $urandom;
            model(we, f3, a, wd, 256, erd, efl, known);
            do_req(0, we, f3, a, wd, rd, fl, lat);
            checks++;
            if (fl !== efl) begin
                failures++;
                $display("FAIL rnd_fault i=%0d we=%b f3=%0d addr=%h got=%b exp=%b", i, we, f3, a, fl, efl);
            end
            if (known) begin
                checks++;
                if (rd !== erd) begin
                    failures++;
                    $display("FAIL rnd_rdata i=%0d we=%b f3=%0d addr=%h got=%h exp=%h", i, we, f3, a, rd, erd);
                end
            end
            checks++;
            if (lat != 1) begin failures++; $display("FAIL rnd_latency i=%0d got=%0d exp=1", i, lat); end
        end
    endtask

    initial begin
        test_reset();
        test_byte_lane();
        test_halfword();
        test_faults();
        test_latency(0, 1);
        test_latency(1, 3);
        test_latency(2, 8);
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
